const_expr_alu: RTL
===================

// Module: const_expr_alu
// PURPOSE
//  Sequential 32-bit operator unit evaluating one SystemVerilog integer-expression operator per
//  transaction. Sits upstream of parameter-consumer stages: it takes an opcode plus two int
//  operands and produces the value handed on as a module parameter. Single-cycle ops complete in
//  1 cycle. Division, modulo and power are iterative. Valid/ready handshake on both sides.
// PARAMETERS
//  W        32   operand/result width (int); all rules below stated for W=32
//  DIV_IT   W    divider iterations (one quotient bit per cycle)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   request valid
//  in_ready   out  1   unit can accept (high only in IDLE)
//  in_op      in   6   opcode, see BEHAVIOUR
//  in_a       in   W   operand a (signed int)
//  in_b       in   W   operand b (signed int; ignored by unary ops)
//  out_valid  out  1   result valid, held until accepted
//  out_ready  in   1   consumer accepts result
//  out_result out  W   result; boolean ops give 0/1 zero-extended
//  out_bool   out  1   result is 1-bit (logical/reduction/compare op)
//  out_err    out  1   div/mod by zero, or unsupported opcode
// BEHAVIOUR
//  Opcodes: 0 +a, 1 -a, 2 ~a, 3 !a, 4 &a, 5 ~&a, 6 |a, 7 ~|a, 8 ^a, 9 ~^a, 10 +, 11 -, 12 *,
//   13 /, 14 %, 15 **, 16 ==/===/==?, 17 !=/!==/!=?, 18 <, 19 <=, 20 >, 21 >=, 22 <</<<<,
//   23 >>, 24 >>>, 25 &, 26 ~&, 27 |, 28 ~|, 29 ^, 30 ~^/^~, 31 &&, 32 ||; 33..63 unsupported.
//  Arithmetic modulo 2^W (wrap, no overflow flag); compares, / and % signed; / truncates toward
//   zero; % sign follows a; shift amount = in_b unsigned, >=W gives 0 (>>>: sign fill).
//  Reset: state IDLE, in_ready=1 after reset, out_valid=0, out_result=0, out_bool=0, out_err=0.
//  FSM: IDLE -> (in_valid & in_ready) -> EXEC1 for single-cycle ops, DIV for 13/14, POW for 15.
//   EXEC1 -> DONE next cycle. DIV: DIV_IT cycles restoring divide on |a|,|b|, sign fix -> DONE.
//   POW: square-and-multiply, exponent bits LSB-first, exits when remaining exponent is 0 -> DONE.
//   DONE: out_valid=1; out_* stable while out_valid & !out_ready; on out_ready -> IDLE.
//  Latency (accept to out_valid): 1 single-cycle, DIV_IT+1 div/mod, popcount-span(b)+1 pow.
//  b==0 on /: result 32'hFFFFFFFF, err=1; on %: result a, err=1; latency 1 (no iteration).
//  ** with b<0: a==1 -> 1, a==-1 -> +/-1 by b parity, a==0 -> 0 with err=1, else 0; latency 1.
//  Unsupported opcode: result 0, out_bool=0, err=1, latency 1.
//  in_ready=0 outside IDLE; no new request is accepted in the same cycle a result is taken
//   (DONE->IDLE first, accept next cycle). Operands are registered at accept; later input changes
//   are ignored.
//  rst asserted mid-DIV/POW/DONE: aborts, returns to reset state next cycle, result discarded.
// CONFIGURATION
//  CONST_EXPR_ALU_POW_EN: defined -> opcode 15 implemented as above (POW state + multiplier
//   reuse). Undefined -> POW state not built; opcode 15 treated as unsupported (result 0, err=1,
//   latency 1).
// TESTING
//  a=42,b=9: op10 -> 51, op11 -> 33, op12 -> 378, op22 -> 21504; each out_valid 1 cycle post accept.
//  a=42,b=9: op13 -> 4, op14 -> 6, latency DIV_IT+1; a=-42,b=9: op13 -> -4, op14 -> -6.
//  a=42,b=3: op15 -> 74088, out_err=0; without CONST_EXPR_ALU_POW_EN -> 0, out_err=1.
//  a=32'hFFFFFFFF,b=9: op23 -> 8388607, op24 -> 32'hFFFFFFFF; a=42: op8 -> 1 out_bool=1, op2 -> 4294967253.
//  a=7,b=0: op13 -> 32'hFFFFFFFF err=1; op14 -> 7 err=1; op40 -> 0 err=1.
//  Hold out_ready=0 for 5 cycles in DONE: out_* stable, in_ready=0; pulse rst mid-DIV -> idle, no out_valid.

Source files
------------

// File: rtl/const_expr_alu_if.sv
// Request/result handshake bundle for const_expr_alu: the master issues operator requests and
// takes results, the slave is the operator unit.
interface const_expr_alu_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_bool;
    logic         out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_bool, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_bool, out_err
    );
endinterface

// File: rtl/const_expr_alu.sv
// Sequential integer-expression operator unit: one opcode per valid/ready transaction.
// Optional macro CONST_EXPR_ALU_POW_EN builds the iterative ** (POW) path; otherwise op 15 errors.
module const_expr_alu #(
    parameter int W      = 32,
    parameter int DIV_IT = W
) (
    input  logic            clk,
    input  logic            rst,
    const_expr_alu_if.slave bus
);
    localparam int SW = $clog2(W);
    localparam int CW = $clog2(DIV_IT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXEC1 = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef CONST_EXPR_ALU_POW_EN
    localparam logic [2:0] S_POW   = 3'd3;
`endif

    logic [2:0]    state_q, state_d;
    logic [5:0]    op_q;
    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  x_q, y_q, z_q;   // div: quotient/remainder/divisor; pow: acc/base/exponent
    logic [CW-1:0] cnt_q;
    logic          neg_q, asg_q;
    logic [W-1:0]  res_q;
    logic          bool_q, err_q;

    logic signed [W-1:0] a_s, b_s;
    logic [W-1:0]  ex_res, mul_x, mul_y, mul_p, abs_a, abs_b, q_fix, r_fix;
    logic          ex_bool, ex_err, sh_big;
    logic [SW-1:0] sh;
    logic [W:0]    rem_sh, diff;

    assign a_s    = a_q;
    assign b_s    = b_q;
    assign sh     = b_q[SW-1:0];
    assign sh_big = (b_q[W-1:SW] != '0);
    assign abs_a  = bus.in_a[W-1] ? -bus.in_a : bus.in_a;
    assign abs_b  = bus.in_b[W-1] ? -bus.in_b : bus.in_b;

    // One shared multiplier: a*b in EXEC1, acc*base while iterating POW
`ifdef CONST_EXPR_ALU_POW_EN
    logic [W-1:0] sq_p;
    assign mul_x = (state_q == S_POW) ? x_q : a_q;
    assign mul_y = (state_q == S_POW) ? y_q : b_q;
    assign sq_p  = y_q * y_q;
`else
    assign mul_x = a_q;
    assign mul_y = b_q;
`endif
    assign mul_p = mul_x * mul_y;

    assign rem_sh = {y_q, x_q[W-1]};
    assign diff   = rem_sh - {1'b0, z_q};
    assign q_fix  = neg_q ? -x_q : x_q;
    assign r_fix  = asg_q ? -y_q : y_q;

    function automatic logic [W-1:0] bw(input logic v);
        bw = {{(W-1){1'b0}}, v};
    endfunction

    always_comb begin
        ex_res  = '0;
        ex_err  = 1'b0;
        ex_bool = (op_q inside {[6'd3:6'd9], [6'd16:6'd21], 6'd31, 6'd32});
        case (op_q)
            6'd0:  ex_res = a_q;
            6'd1:  ex_res = -a_q;
            6'd2:  ex_res = ~a_q;
            6'd3:  ex_res = bw(a_q == '0);
            6'd4:  ex_res = bw(&a_q);
            6'd5:  ex_res = bw(~&a_q);
            6'd6:  ex_res = bw(|a_q);
            6'd7:  ex_res = bw(~|a_q);
            6'd8:  ex_res = bw(^a_q);
            6'd9:  ex_res = bw(~^a_q);
            6'd10: ex_res = a_q + b_q;
            6'd11: ex_res = a_q - b_q;
            6'd12: ex_res = mul_p;
            6'd13: begin ex_res = '1;  ex_err = 1'b1; end
            6'd14: begin ex_res = a_q; ex_err = 1'b1; end
`ifdef CONST_EXPR_ALU_POW_EN
            // Only negative exponents reach EXEC1 for **
            6'd15: begin
                if (a_q == W'(1))   ex_res = W'(1);
                else if (a_q == '1) ex_res = b_q[0] ? '1 : W'(1);
                else if (a_q == '0) ex_err = 1'b1;
            end
`endif
            6'd16: ex_res = bw(a_q == b_q);
            6'd17: ex_res = bw(a_q != b_q);
            6'd18: ex_res = bw(a_s < b_s);
            6'd19: ex_res = bw(a_s <= b_s);
            6'd20: ex_res = bw(a_s > b_s);
            6'd21: ex_res = bw(a_s >= b_s);
            6'd22: ex_res = sh_big ? '0 : (a_q << sh);
            6'd23: ex_res = sh_big ? '0 : (a_q >> sh);
            6'd24: ex_res = sh_big ? {W{a_q[W-1]}} : W'(a_s >>> sh);
            6'd25: ex_res = a_q & b_q;
            6'd26: ex_res = ~(a_q & b_q);
            6'd27: ex_res = a_q | b_q;
            6'd28: ex_res = ~(a_q | b_q);
            6'd29: ex_res = a_q ^ b_q;
            6'd30: ex_res = ~(a_q ^ b_q);
            6'd31: ex_res = bw((a_q != '0) && (b_q != '0));
            6'd32: ex_res = bw((a_q != '0) || (b_q != '0));
            default: ex_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                if ((bus.in_op == 6'd13 || bus.in_op == 6'd14) && bus.in_b != '0)
                    state_d = S_DIV;
`ifdef CONST_EXPR_ALU_POW_EN
                else if (bus.in_op == 6'd15 && !bus.in_b[W-1])
                    state_d = S_POW;
`endif
                else
                    state_d = S_EXEC1;
            end
            S_EXEC1: state_d = S_DONE;
            S_DIV:   if (cnt_q == '0) state_d = S_DONE;
`ifdef CONST_EXPR_ALU_POW_EN
            S_POW:   if (z_q == '0) state_d = S_DONE;
`endif
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            asg_q   <= 1'b0;
            res_q   <= '0;
            bool_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    op_q  <= bus.in_op;
                    a_q   <= bus.in_a;
                    b_q   <= bus.in_b;
                    neg_q <= bus.in_a[W-1] ^ bus.in_b[W-1];
                    asg_q <= bus.in_a[W-1];
                    cnt_q <= CW'(DIV_IT);
`ifdef CONST_EXPR_ALU_POW_EN
                    if (bus.in_op == 6'd15) begin
                        x_q <= W'(1);
                        y_q <= bus.in_a;
                        z_q <= bus.in_b;
                    end else
`endif
                    begin
                        x_q <= abs_a;
                        y_q <= '0;
                        z_q <= abs_b;
                    end
                end
                S_EXEC1: begin
                    res_q  <= ex_res;
                    bool_q <= ex_bool;
                    err_q  <= ex_err;
                end
                S_DIV: begin
                    if (cnt_q != '0) begin
                        // Restoring step: shift next dividend bit in, subtract if it fits
                        if (!diff[W]) begin
                            y_q <= diff[W-1:0];
                            x_q <= {x_q[W-2:0], 1'b1};
                        end else begin
                            y_q <= rem_sh[W-1:0];
                            x_q <= {x_q[W-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        res_q  <= (op_q == 6'd14) ? r_fix : q_fix;
                        bool_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
`ifdef CONST_EXPR_ALU_POW_EN
                S_POW: begin
                    if (z_q != '0) begin
                        if (z_q[0]) x_q <= mul_p;
                        y_q <= sq_p;
                        z_q <= z_q >> 1;
                    end else begin
                        res_q  <= x_q;
                        bool_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = res_q;
    assign bus.out_bool   = bool_q;
    assign bus.out_err    = err_q;
endmodule
